// File: rtl/oc_pkg.sv
// Shared definitions for the overcurrent guard: per-channel state encoding
// and trip counter width.
package oc_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOCKOUT = 2'd1,
        LATCHED = 2'd2
    } oc_state_e;

    localparam int TRIP_CNT_W = 4;
    localparam logic [TRIP_CNT_W-1:0] TRIP_CNT_MAX = '1;

endpackage

// File: rtl/oc_channel.sv
// One overcurrent channel: OC synchronizer, debounce/lockout/clean counters,
// RUN/LOCKOUT/LATCHED state machine and enable gating.
module oc_channel
    import oc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100,
    parameter int LOCKOUT_CYC  = 50000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  oc_i,
    input  logic                  clear_fault_i,
    output logic                  en_o,
    output logic                  trip_o,
    output logic                  fault_o,
    output logic [TRIP_CNT_W-1:0] trip_cnt_o
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam logic [DW-1:0]         DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0]         LK_LAST    = LW'(LOCKOUT_CYC - 1);
    localparam logic [LW-1:0]         CLEAN_DONE = LW'(LOCKOUT_CYC);
    localparam logic [TRIP_CNT_W-1:0] RETRY_LIM  = TRIP_CNT_W'(MAX_RETRY);

    oc_state_e             state_q;
    logic                  sync1_q, sync2_q;
    logic [DW-1:0]         deb_cnt_q;
    logic [LW-1:0]         lk_cnt_q;
    logic [LW-1:0]         clean_cnt_q;
    logic [TRIP_CNT_W-1:0] trip_cnt_q;
    logic [TRIP_CNT_W-1:0] trip_cnt_d;
    logic                  oc_sync;

    assign oc_sync = sync2_q;

    // Saturating increment used on the trip edge.
    always_comb begin
        trip_cnt_d = trip_cnt_q;
        if (trip_cnt_q != TRIP_CNT_MAX) begin
            trip_cnt_d = trip_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            lk_cnt_q    <= '0;
            clean_cnt_q <= '0;
            trip_cnt_q  <= '0;
        end else begin
            sync1_q <= oc_i;
            sync2_q <= sync1_q;
            case (state_q)
                RUN: begin
                    lk_cnt_q <= '0;
                    if (oc_sync) begin
                        clean_cnt_q <= '0;
                        if (deb_cnt_q == DEB_LAST) begin
                            deb_cnt_q  <= '0;
                            trip_cnt_q <= trip_cnt_d;
                            state_q    <= (trip_cnt_d >= RETRY_LIM) ? LATCHED : LOCKOUT;
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                            if (clear_fault_i) begin
                                trip_cnt_q <= '0;
                            end
                        end
                    end else begin
                        deb_cnt_q <= '0;
                        // A clean run of LOCKOUT_CYC edges forgets earlier trips.
                        if (clear_fault_i || (clean_cnt_q >= LK_LAST)) begin
                            trip_cnt_q <= '0;
                        end
                        if (clean_cnt_q != CLEAN_DONE) begin
                            clean_cnt_q <= clean_cnt_q + 1'b1;
                        end
                    end
                end
                LOCKOUT: begin
                    deb_cnt_q   <= '0;
                    clean_cnt_q <= '0;
                    if (lk_cnt_q == LK_LAST) begin
                        lk_cnt_q <= '0;
                        state_q  <= RUN;
                    end else begin
                        lk_cnt_q <= lk_cnt_q + 1'b1;
                    end
                end
                LATCHED: begin
                    deb_cnt_q   <= '0;
                    clean_cnt_q <= '0;
                    lk_cnt_q    <= '0;
                    if (clear_fault_i && !oc_sync) begin
                        trip_cnt_q <= '0;
                        state_q    <= RUN;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign en_o       = req_i & (state_q == RUN) & ~rst_i;
    assign trip_o     = (state_q == LOCKOUT);
    assign fault_o    = (state_q == LATCHED);
    assign trip_cnt_o = trip_cnt_q;

endmodule

// File: rtl/oc_guard.sv
// Overcurrent guard for the two H-bridge enables; each motor channel is an
// independent oc_channel instance.
module oc_guard
    import oc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 100,
    parameter int LOCKOUT_CYC  = 50000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  ena_req,
    input  logic                  enb_req,
    input  logic                  OCA,
    input  logic                  OCB,
    input  logic                  clear_fault,
    output logic                  ENA,
    output logic                  ENB,
    output logic                  trip_a,
    output logic                  trip_b,
    output logic                  fault_a,
    output logic                  fault_b,
    output logic [TRIP_CNT_W-1:0] trip_cnt_a,
    output logic [TRIP_CNT_W-1:0] trip_cnt_b
);

    oc_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LOCKOUT_CYC  (LOCKOUT_CYC),
        .MAX_RETRY    (MAX_RETRY)
    ) u_ch_a (
        .clk_i         (CLK100MHZ),
        .rst_i         (rst),
        .req_i         (ena_req),
        .oc_i          (OCA),
        .clear_fault_i (clear_fault),
        .en_o          (ENA),
        .trip_o        (trip_a),
        .fault_o       (fault_a),
        .trip_cnt_o    (trip_cnt_a)
    );

    oc_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .LOCKOUT_CYC  (LOCKOUT_CYC),
        .MAX_RETRY    (MAX_RETRY)
    ) u_ch_b (
        .clk_i         (CLK100MHZ),
        .rst_i         (rst),
        .req_i         (enb_req),
        .oc_i          (OCB),
        .clear_fault_i (clear_fault),
        .en_o          (ENB),
        .trip_o        (trip_b),
        .fault_o       (fault_b),
        .trip_cnt_o    (trip_cnt_b)
    );

endmodule
